filter_ctrl: RTL and testbench

Controller for the gray/Gaussian/Sobel/Canny edge pipeline. It holds the run-time filter configuration (Canny thresholds and gray brightness offsets) in host-writable shadow registers and applies them only at frame boundaries. It also sequences single-frame capture of the pipeline output into the plotter frame buffer by generating write-enable and address. It sits between the host command path (UART/MCU bridge), the filter chain, and the frame buffer.

---
 rtl/filter_ctrl_pkg.sv | 25 ++
 rtl/filter_ctrl_if.sv | 24 ++
 rtl/filter_ctrl_regs.sv | 71 +++++++
 rtl/filter_ctrl.sv | 162 ++++++++++++++++
 tb/tb_filter_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/filter_ctrl_pkg.sv
// Shared types and constants for the edge-pipeline filter controller.
// Holds the FSM state enum, register map and frame-size helper.
package filter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE
  } state_t;

  localparam logic [2:0] REG_TH_HIGH = 3'd0;
  localparam logic [2:0] REG_TH_LOW  = 3'd1;
  localparam logic [2:0] REG_BR_ADD  = 3'd2;
  localparam logic [2:0] REG_BR_SUB  = 3'd3;
  localparam logic [2:0] REG_CTRL    = 3'd4;

  localparam int CTRL_START   = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_CLR_ERR = 2;

  function automatic int frame_pixels(input int h, input int v);
    return h * v;
  endfunction

endpackage

// File: rtl/filter_ctrl_if.sv
// Host command write channel of the filter controller.
// Valid/ready write with a 3-bit register address and 8-bit data.
interface filter_ctrl_if;

  logic       valid;
  logic       ready;
  logic [2:0] addr;
  logic [7:0] data;

  modport master (
    output valid,
    output addr,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  addr,
    input  data,
    output ready
  );

endinterface

// File: rtl/filter_ctrl_regs.sv
// Shadow/active filter configuration registers and command decode.
// Active values load from shadow on each frame boundary.
module filter_ctrl_regs
  import filter_ctrl_pkg::*;
#(
  parameter int DEF_TH_HIGH = 255,
  parameter int DEF_TH_LOW  = 250,
  parameter int DEF_BRIGHT  = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             vs_rise,
  filter_ctrl_if.slave     cmd,
  output logic [7:0]       th_high,
  output logic [7:0]       th_low,
  output logic [7:0]       bright_add,
  output logic [7:0]       bright_sub,
  output logic             start,
  output logic             abort,
  output logic             clr_err
);

  logic [7:0] sh_high;
  logic [7:0] sh_low;
  logic [7:0] sh_add;
  logic [7:0] sh_sub;
  logic       wr;
  logic       is_ctrl;

  assign cmd.ready = 1'b1;
  assign wr        = cmd.valid & cmd.ready;
  assign is_ctrl   = wr && (cmd.addr == REG_CTRL);

  assign abort   = is_ctrl & cmd.data[CTRL_ABORT];
  assign start   = is_ctrl & cmd.data[CTRL_START]
                 & ~cmd.data[CTRL_ABORT];
  assign clr_err = is_ctrl & cmd.data[CTRL_CLR_ERR];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_high <= 8'(DEF_TH_HIGH);
      sh_low  <= 8'(DEF_TH_LOW);
      sh_add  <= 8'(DEF_BRIGHT);
      sh_sub  <= 8'(DEF_BRIGHT);
    end else if (wr) begin
      unique case (1'b1)
        (cmd.addr == REG_TH_HIGH): sh_high <= cmd.data;
        (cmd.addr == REG_TH_LOW):  sh_low  <= cmd.data;
        (cmd.addr == REG_BR_ADD):  sh_add  <= cmd.data;
        (cmd.addr == REG_BR_SUB):  sh_sub  <= cmd.data;
        default: ;
      endcase
    end
  end

  // Low threshold never exceeds high; clamp at apply time.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      th_high    <= 8'(DEF_TH_HIGH);
      th_low     <= 8'(DEF_TH_LOW);
      bright_add <= 8'(DEF_BRIGHT);
      bright_sub <= 8'(DEF_BRIGHT);
    end else if (vs_rise) begin
      th_high    <= sh_high;
      th_low     <= (sh_low > sh_high) ? sh_high : sh_low;
      bright_add <= sh_add;
      bright_sub <= sh_sub;
    end
  end

endmodule

// File: rtl/filter_ctrl.sv
// Filter controller top: vsync edge, capture FSM, pixel counters.
// Optional watchdog enabled by FILTER_CTRL_TIMEOUT_EN.
module filter_ctrl
  import filter_ctrl_pkg::*;
#(
  parameter int H_RES          = 640,
  parameter int V_RES          = 480,
  parameter int ADDR_W         = 19,
  parameter int DEF_TH_HIGH    = 255,
  parameter int DEF_TH_LOW     = 250,
  parameter int DEF_BRIGHT     = 0,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_vsync,
  input  logic              i_de,
  filter_ctrl_if.slave      cmd,
  output logic [7:0]        o_th_high,
  output logic [7:0]        o_th_low,
  output logic [7:0]        o_bright_add,
  output logic [7:0]        o_bright_sub,
  output logic              o_pix_we,
  output logic [ADDR_W-1:0] o_pix_addr,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int FRAME = frame_pixels(H_RES, V_RES);
  localparam logic [ADDR_W:0] FRAME_CNT = (ADDR_W+1)'(FRAME);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME-1);

  state_t            state;
  state_t            state_n;
  logic              vsync_d;
  logic              vs_rise;
  logic              start;
  logic              abort;
  logic              clr_err;
  logic              timeout;
  logic              cap_clr;
  logic              done_n;
  logic              err_set;
  logic              in_cap;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W-1:0] addr;

  filter_ctrl_regs #(
    .DEF_TH_HIGH (DEF_TH_HIGH),
    .DEF_TH_LOW  (DEF_TH_LOW),
    .DEF_BRIGHT  (DEF_BRIGHT)
  ) u_regs (
    .clk        (clk),
    .rstn       (rstn),
    .vs_rise    (vs_rise),
    .cmd        (cmd),
    .th_high    (o_th_high),
    .th_low     (o_th_low),
    .bright_add (o_bright_add),
    .bright_sub (o_bright_sub),
    .start      (start),
    .abort      (abort),
    .clr_err    (clr_err)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) vsync_d <= 1'b0;
    else       vsync_d <= i_vsync;
  end

  assign vs_rise = i_vsync & ~vsync_d;

`ifdef FILTER_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES-1);

  logic [WD_W-1:0] wdog;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      wdog <= '0;
    else if (state == IDLE || vs_rise)
      wdog <= '0;
    else if (wdog != WD_LAST)
      wdog <= wdog + 1'b1;
  end

  assign timeout = (state != IDLE) && (wdog == WD_LAST) && !vs_rise;
`else
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    cap_clr = 1'b0;
    done_n  = 1'b0;
    err_set = 1'b0;
    unique case (state)
      IDLE:    if (start) state_n = ARMED;
      ARMED:   if (vs_rise) begin
                 state_n = CAPTURE;
                 cap_clr = 1'b1;
               end
      CAPTURE: if (vs_rise) begin
                 state_n = IDLE;
                 done_n  = 1'b1;
                 err_set = (cnt != FRAME_CNT);
               end
      default: state_n = IDLE;
    endcase
    if (timeout) begin
      state_n = IDLE;
      done_n  = 1'b0;
      cap_clr = 1'b0;
      err_set = 1'b1;
    end
    if (abort) begin
      state_n = IDLE;
      done_n  = 1'b0;
      cap_clr = 1'b0;
      err_set = 1'b0;
    end
  end

  // Excess pixels are counted but never written past the last address.
  assign in_cap   = (state == CAPTURE);
  assign o_pix_we = in_cap & i_de & (cnt < FRAME_CNT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt  <= '0;
      addr <= '0;
    end else if (cap_clr) begin
      cnt  <= '0;
      addr <= '0;
    end else if (in_cap && i_de) begin
      if (~&cnt) cnt <= cnt + 1'b1;
      if (o_pix_we && addr != LAST_ADDR) addr <= addr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
    end else begin
      o_done <= done_n;
      if (err_set)      o_err <= 1'b1;
      else if (clr_err) o_err <= 1'b0;
    end
  end

  assign o_pix_addr = addr;
  assign o_busy     = (state != IDLE);

endmodule

// File: tb/tb_filter_ctrl.sv
// Directed self-checking bench for filter_ctrl on a reduced 8x4 frame.
// Timeout scenario follows FILTER_CTRL_TIMEOUT_EN when defined.
module tb_filter_ctrl;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int AW = 6;
  localparam int FP = H * V;

  logic          clk;
  logic          rstn;
  logic          i_vsync;
  logic          i_de;
  logic [7:0]    th_high;
  logic [7:0]    th_low;
  logic [7:0]    br_add;
  logic [7:0]    br_sub;
  logic          pix_we;
  logic [AW-1:0] pix_addr;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int done_cnt = 0;

  filter_ctrl_if cmd_bus ();

  filter_ctrl #(
    .H_RES          (H),
    .V_RES          (V),
    .ADDR_W         (AW),
    .DEF_TH_HIGH    (255),
    .DEF_TH_LOW     (250),
    .DEF_BRIGHT     (0),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_vsync      (i_vsync),
    .i_de         (i_de),
    .cmd          (cmd_bus),
    .o_th_high    (th_high),
    .o_th_low     (th_low),
    .o_bright_add (br_add),
    .o_bright_sub (br_sub),
    .o_pix_we     (pix_we),
    .o_pix_addr   (pix_addr),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pix_we) we_cnt++;
    if (done)   done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cmd_bus.valid = 1'b1;
    cmd_bus.addr  = a;
    cmd_bus.data  = d;
    tick();
    cmd_bus.valid = 1'b0;
  endtask

  task automatic vs_pulse();
    i_vsync = 1'b1;
    tick();
    tick();
    i_vsync = 1'b0;
    tick();
  endtask

  task automatic send_line(input int px);
    i_de = 1'b1;
    repeat (px) tick();
    i_de = 1'b0;
    repeat (2) tick();
  endtask

  task automatic frame(input int lines);
    vs_pulse();
    repeat (2) tick();
    for (int l = 0; l < lines; l++) send_line(H);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    i_vsync = 1'b0;
    i_de = 1'b0;
    cmd_bus.valid = 1'b0;
    cmd_bus.addr = '0;
    cmd_bus.data = '0;
    repeat (3) tick();
    chk("rst_th_high", th_high, 255);
    chk("rst_th_low", th_low, 250);
    chk("rst_br_add", br_add, 0);
    chk("rst_br_sub", br_sub, 0);
    chk("rst_ready", cmd_bus.ready, 1);
    chk("rst_we", pix_we, 0);
    chk("rst_addr", pix_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_config();
    wr(3'd1, 8'd200);
    wr(3'd0, 8'd100);
    wr(3'd2, 8'd7);
    wr(3'd3, 8'd9);
    tick();
    chk("cfg_hold_high", th_high, 255);
    chk("cfg_hold_low", th_low, 250);
    vs_pulse();
    chk("cfg_high", th_high, 100);
    chk("cfg_low_clamp", th_low, 100);
    chk("cfg_br_add", br_add, 7);
    chk("cfg_br_sub", br_sub, 9);
    i_vsync = 1'b1;
    wr(3'd0, 8'd120);
    tick();
    i_vsync = 1'b0;
    tick();
    chk("cfg_coinc_old", th_high, 100);
    vs_pulse();
    chk("cfg_coinc_new", th_high, 120);
    chk("cfg_coinc_low", th_low, 120);
  endtask

  task automatic test_capture();
    int w0;
    int d0;
    d0 = done_cnt;
    wr(3'd4, 8'h01);
    chk("cap_busy", busy, 1);
    w0 = we_cnt;
    send_line(H);
    chk("cap_armed_no_we", we_cnt - w0, 0);
    frame(V);
    frame(V);
    repeat (2) tick();
    chk("cap_we_count", we_cnt - w0, FP);
    chk("cap_last_addr", pix_addr, FP - 1);
    chk("cap_done", done_cnt - d0, 1);
    chk("cap_err", err, 0);
    chk("cap_idle", busy, 0);
  endtask

  task automatic test_short_frame();
    int d0;
    d0 = done_cnt;
    wr(3'd4, 8'h01);
    frame(V - 1);
    vs_pulse();
    tick();
    chk("short_done", done_cnt - d0, 1);
    chk("short_err", err, 1);
    wr(3'd4, 8'h04);
    chk("short_clr", err, 0);
  endtask

  task automatic test_overflow();
    int w0;
    wr(3'd4, 8'h01);
    w0 = we_cnt;
    frame(V + 1);
    vs_pulse();
    tick();
    chk("ovf_we_count", we_cnt - w0, FP);
    chk("ovf_addr_sat", pix_addr, FP - 1);
    chk("ovf_err", err, 1);
    wr(3'd4, 8'h04);
  endtask

  task automatic test_abort();
    int w0;
    int d0;
    d0 = done_cnt;
    wr(3'd4, 8'h01);
    vs_pulse();
    w0 = we_cnt;
    i_de = 1'b1;
    repeat (10) tick();
    wr(3'd4, 8'h03);
    chk("abort_busy", busy, 0);
    repeat (10) tick();
    i_de = 1'b0;
    vs_pulse();
    tick();
    chk("abort_we_count", we_cnt - w0, 11);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_err_keep", err, 0);
  endtask

  task automatic test_start_vs();
    int w0;
    int d0;
    d0 = done_cnt;
    i_vsync = 1'b1;
    wr(3'd4, 8'h01);
    chk("svs_armed", busy, 1);
    tick();
    i_vsync = 1'b0;
    tick();
    w0 = we_cnt;
    send_line(H);
    chk("svs_no_we", we_cnt - w0, 0);
    chk("svs_still_armed", busy, 1);
    frame(V);
    vs_pulse();
    tick();
    chk("svs_we_count", we_cnt - w0, FP);
    chk("svs_done", done_cnt - d0, 1);
    chk("svs_err", err, 0);
  endtask

  task automatic test_reset_mid();
    wr(3'd4, 8'h01);
    vs_pulse();
    i_de = 1'b1;
    repeat (5) tick();
    rstn = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_addr", pix_addr, 0);
    chk("mid_we", pix_we, 0);
    chk("mid_th_high", th_high, 255);
    i_de = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_timeout();
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    wr(3'd4, 8'h01);
`ifdef FILTER_CTRL_TIMEOUT_EN
    for (int i = 0; i < 200; i++) begin
      tick();
      n++;
      if (err) break;
    end
    chk("to_cycles", n, 100);
    chk("to_err", err, 1);
    chk("to_busy", busy, 0);
    chk("to_no_done", done_cnt - d0, 0);
    wr(3'd4, 8'h04);
`else
    repeat (150) begin
      tick();
      n++;
    end
    chk("wait_busy", busy, 1);
    chk("wait_err", err, 0);
    wr(3'd4, 8'h02);
    chk("wait_abort", busy, 0);
    chk("wait_no_done", done_cnt - d0, 0);
`endif
  endtask

  initial begin
    test_reset();
    test_config();
    test_capture();
    test_short_frame();
    test_overflow();
    test_abort();
    test_start_vs();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
